led_replay_ctrl: RTL and testbench

Command recorder and replay sequencer between the UART receiver/transmitter and the five board LEDs. Decodes received command bytes, toggles LEDs live, and records each toggle with its inter-command delay in a small buffer. On the replay command it re-runs the recorded sequence with the original timing, sharing the single UART transmit slot between live echo and replayed-command output.

---
 rtl/led_replay_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_led_replay_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_replay_ctrl.sv
// LED command recorder and timed replay sequencer.
// Shares one UART transmit slot between live echo and replayed commands.
module led_replay_ctrl #(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 1200,
    parameter int DELTA_W  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic [4:0] leds,
    output logic       busy,
    output logic       overflow
);
    localparam int CW = $clog2(DEPTH);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int EW = DELTA_W + 3;
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);
    localparam logic [CW:0] ONE = (CW + 1)'(1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE = TW'(1);
    localparam logic [DELTA_W-1:0] DELTA_MAX = '1;
    localparam logic [DELTA_W-1:0] DELTA_ONE = DELTA_W'(1);

    typedef enum logic [1:0] {
        REC,
        REPLAY_WAIT,
        REPLAY_FIRE
    } state_t;

    state_t state, state_n;
    logic [4:0] base, base_n, live, live_n, leds_n;
    logic [CW:0] count, count_n, ptr_inc;
    logic [CW-1:0] ptr, ptr_n;
    logic [DELTA_W-1:0] wait_cnt, wait_n, delta, delta_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic busy_n, ovf_n, tx_valid_n, wr_en;
    logic [7:0] tx_data_n;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] cur_ent, next_ent;
    logic [2:0] cmd_idx, fire_idx;
    logic tick, slot_free, is_cmd, is_abort;

    assign tick      = (tick_cnt == TICK_LAST);
    assign slot_free = !tx_valid || tx_ready;
    assign cmd_idx   = rx_data[2:0];
    assign is_cmd    = (rx_data >= 8'h31) && (rx_data <= 8'h35);
    assign is_abort  = rx_valid && (rx_data == 8'h78);
    assign ptr_inc   = {1'b0, ptr} + ONE;
    assign cur_ent   = mem[ptr];
    assign next_ent  = mem[ptr_inc[CW-1:0]];
    assign fire_idx  = cur_ent[EW-1 -: 3];

    always_comb begin
        state_n    = state;
        leds_n     = leds;
        base_n     = base;
        live_n     = live;
        count_n    = count;
        ptr_n      = ptr;
        wait_n     = wait_cnt;
        busy_n     = busy;
        ovf_n      = overflow;
        tx_valid_n = tx_valid && !tx_ready;
        tx_data_n  = tx_data;
        wr_en      = 1'b0;
        tick_n     = tick ? '0 : tick_cnt + TICK_ONE;
        delta_n    = (tick && delta != DELTA_MAX) ? delta + DELTA_ONE : delta;
        unique case (state)
            REC: begin
                if (rx_valid) begin
                    if (slot_free) begin
                        tx_valid_n = 1'b1;
                        tx_data_n  = rx_data;
                    end
                    unique case (1'b1)
                        is_cmd: begin
                            leds_n = leds ^ (5'b00001 << (cmd_idx - 3'd1));
                            if (count < FULL) begin
                                wr_en   = 1'b1;
                                count_n = count + ONE;
                                delta_n = '0;
                            end else begin
                                ovf_n = 1'b1;
                            end
                        end
                        (rx_data == 8'h30 && count != '0): begin
                            live_n  = leds;
                            leds_n  = base;
                            ptr_n   = '0;
                            busy_n  = 1'b1;
                            tick_n  = '0;
                            wait_n  = mem[0][DELTA_W-1:0];
                            state_n = REPLAY_WAIT;
                        end
                        (rx_data == 8'h63): begin
                            count_n = '0;
                            base_n  = leds;
                            ovf_n   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            REPLAY_WAIT, REPLAY_FIRE: begin
                if (is_abort) begin
                    // Abort wins over any fire due this cycle.
                    leds_n  = live;
                    busy_n  = 1'b0;
                    delta_n = '0;
                    state_n = REC;
                    if (slot_free) begin
                        tx_valid_n = 1'b1;
                        tx_data_n  = rx_data;
                    end
                end else if (state == REPLAY_WAIT) begin
                    if (wait_cnt == '0) state_n = REPLAY_FIRE;
                    else if (tick) wait_n = wait_cnt - DELTA_ONE;
                end else if (slot_free) begin
                    tx_valid_n = 1'b1;
                    tx_data_n  = 8'h30 + {5'd0, fire_idx};
                    ptr_n      = ptr_inc[CW-1:0];
                    if (ptr_inc == count) begin
                        leds_n  = live;
                        busy_n  = 1'b0;
                        delta_n = '0;
                        state_n = REC;
                    end else begin
                        leds_n  = leds ^ (5'b00001 << (fire_idx - 3'd1));
                        wait_n  = next_ent[DELTA_W-1:0];
                        state_n = REPLAY_WAIT;
                    end
                end
            end
            default: state_n = REC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= REC;
            leds     <= '0;
            base     <= '0;
            live     <= '0;
            count    <= '0;
            ptr      <= '0;
            wait_cnt <= '0;
            delta    <= '0;
            tick_cnt <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            state    <= state_n;
            leds     <= leds_n;
            base     <= base_n;
            live     <= live_n;
            count    <= count_n;
            ptr      <= ptr_n;
            wait_cnt <= wait_n;
            delta    <= delta_n;
            tick_cnt <= tick_n;
            busy     <= busy_n;
            overflow <= ovf_n;
            tx_valid <= tx_valid_n;
            tx_data  <= tx_data_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[count[CW-1:0]] <= {cmd_idx, delta};
        end
    end

endmodule

// File: tb/tb_led_replay_ctrl.sv
// Bench for led_replay_ctrl: event-level model of recording/replay
// checked every cycle, plus directed literal expectations.
module tb_led_replay_ctrl;
    localparam int DEPTH = 4;
    localparam int TDIV  = 10;
    localparam int DW    = 8;
    localparam int SLACK = 2 * TDIV + 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic tx_ready = 1'b1;
    logic tx_valid;
    logic [7:0] tx_data;
    logic [4:0] leds;
    logic busy, overflow;

    led_replay_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TDIV), .DELTA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .leds(leds), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total = 0;

    // Model state: what the outputs must be, from the command rules.
    logic [4:0] m_leds = '0, m_base = '0, m_live = '0;
    bit m_busy = 0, m_ovf = 0;
    int m_cnt = 0;
    int e_idx[$];
    int e_gap[$];
    int echo_q[$];
    int fire_log[$];
    int r_pos = 0, last_fire = 0, last_clear = 0, stall = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic chk_range(input string name, input int act,
                             input int lo, input int hi);
        total++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    endtask

    task automatic model_reset();
        m_leds = '0; m_base = '0; m_live = '0;
        m_busy = 0; m_ovf = 0; m_cnt = 0; r_pos = 0;
        e_idx.delete(); e_gap.delete(); echo_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; the byte is sampled at the next edge.
    task automatic send(input logic [7:0] b, input bit slot_free = 1);
        int g;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (!m_busy) begin
            if (b >= "1" && b <= "5") begin
                m_leds = m_leds ^ 5'(1 << (b - "1"));
                if (m_cnt < DEPTH) begin
                    g = cyc - last_clear;
                    if (g > 255 * TDIV) g = 255 * TDIV;
                    e_idx.push_back(int'(b));
                    e_gap.push_back(g);
                    last_clear = cyc;
                    m_cnt++;
                end else m_ovf = 1;
            end else if (b == "0" && m_cnt > 0) begin
                m_live = m_leds; m_leds = m_base; m_busy = 1;
                r_pos = 0; last_fire = cyc; stall = 0;
            end else if (b == "c") begin
                m_cnt = 0; e_idx.delete(); e_gap.delete();
                m_base = m_leds; m_ovf = 0;
            end
            if (slot_free) echo_q.push_back(int'(b));
        end else if (b == "x") begin
            m_leds = m_live; m_busy = 0; last_clear = cyc;
            if (slot_free) echo_q.push_back(int'(b));
        end
    endtask

    task automatic on_byte(input int b);
        int g;
        if (echo_q.size() > 0) begin
            chk("echo_byte", b, echo_q.pop_front());
        end else if (m_busy) begin
            chk("fire_byte", b, e_idx[r_pos]);
            g = cyc - last_fire;
            chk_range("fire_gap", g, e_gap[r_pos] - SLACK,
                      e_gap[r_pos] + SLACK + stall);
            fire_log.push_back(cyc);
            m_leds = m_leds ^ 5'(1 << (e_idx[r_pos] - "1"));
            last_fire = cyc; stall = 0; r_pos++;
            if (r_pos == m_cnt) begin
                m_busy = 0; m_leds = m_live; last_clear = cyc;
            end
        end else begin
            chk("spurious_tx", b, -1);
        end
    endtask

    logic pv = 1'b0, pr = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0; pr = 1'b0;
        end else begin
            if (tx_valid && (!pv || pr)) on_byte(int'(tx_data));
            if (m_busy && !tx_ready) stall++;
            chk("leds", leds, m_leds);
            chk("busy", busy, m_busy);
            chk("overflow", overflow, m_ovf);
            pv = tx_valid; pr = tx_ready;
        end
    end

    task automatic wait_done(input int limit);
        int n = 0;
        while ((m_busy || echo_q.size() > 0) && n < limit) begin
            idle(1); n++;
        end
        chk("done_in_time", int'(m_busy || echo_q.size() > 0), 0);
    endtask

    task automatic wait_fires(input int k, input int limit);
        int n = 0;
        while (fire_log.size() < k && n < limit) begin
            idle(1); n++;
        end
        chk("fire_in_time", int'(fire_log.size() >= k), 1);
    endtask

    task automatic chk_zero_outputs();
        chk("rst_leds", leds, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_overflow", overflow, 0);
    endtask

    initial begin
        idle(3);
        chk_zero_outputs();
        rst_n = 1'b1;
        last_clear = cyc;
        idle(20);

        // Record two toggles 50 cycles apart, then replay them.
        send("1");
        idle(49);
        send("3");
        idle(5);
        chk("rec_leds", leds, 5'b00101);
        chk("rec_entry1_gap", e_gap[1], 50);
        fire_log.delete();
        send("0");
        wait_done(2000);
        chk("replay1_fires", fire_log.size(), 2);
        if (fire_log.size() == 2)
            chk_range("gap_1_to_3", fire_log[1] - fire_log[0], 40, 60);
        chk("replay1_leds", leds, 5'b00101);
        chk("replay1_busy", busy, 0);

        // Fill the buffer, clear, then overflow with five toggles.
        send("1"); idle(30);
        send("3"); idle(10);
        send("c"); idle(5);
        for (int i = 0; i < 5; i++) begin
            send(8'("1" + i));
            idle(20);
        end
        chk("ovf_leds", leds, 5'b11111);
        chk("ovf_flag", overflow, 1);
        fire_log.delete();
        send("0");
        idle(3);
        send("q");
        wait_done(3000);
        chk("ovf_replay_fires", fire_log.size(), 4);
        chk("ovf_replay_leds", leds, 5'b11111);

        // Abort after the first fire, then a full replay again.
        fire_log.delete();
        send("0");
        wait_fires(1, 1000);
        send("x");
        chk("abort_busy", busy, 0);
        chk("abort_leds", leds, 5'b11111);
        wait_done(100);
        fire_log.delete();
        send("0");
        wait_done(3000);
        chk("rereplay_fires", fire_log.size(), 4);

        // Transmitter stalled for 40 cycles at replay start.
        tx_ready = 1'b0;
        fire_log.delete();
        send("0");
        idle(40);
        chk("stall_leds", leds, 5'b00000);
        chk("stall_busy", busy, 1);
        chk("stall_no_fire", fire_log.size(), 0);
        tx_ready = 1'b1;
        wait_done(3000);
        chk("stall_fires", fire_log.size(), 4);

        // Echo dropped while the slot is occupied.
        tx_ready = 1'b0;
        send("a");
        send("b", 0);
        idle(5);
        tx_ready = 1'b1;
        idle(5);
        chk("drop_pending", echo_q.size(), 0);

        // Asynchronous reset in the middle of a replay.
        fire_log.delete();
        send("0");
        wait_fires(1, 1000);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_zero_outputs();
        model_reset();
        idle(2);
        rst_n = 1'b1;
        last_clear = cyc;
        idle(3);
        send("0");
        idle(5);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_echo", echo_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
